// File: rtl/obi_instr_mem_responder.sv
// OBI instruction-fetch responder: grants word reads, drives a synchronous SRAM and
// returns in-order responses a fixed number of cycles after each grant.
module obi_instr_mem_responder #(
    parameter int unsigned MEM_AW          = 12,
    parameter int unsigned RESP_LATENCY    = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              obi_req_i,
    output logic              obi_gnt_o,
    input  logic [31:0]       obi_addr_i,
    output logic              obi_rvalid_o,
    output logic [31:0]       obi_rdata_o,
    output logic              obi_err_o,
    input  logic              stall_i,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [RESP_LATENCY-1:0] vld_q, vld_d;
    logic [RESP_LATENCY-1:0] err_q, err_d;
    logic                    gnt;
    logic                    err_t;
    logic                    rvalid;
    logic                    rerr;
    logic [31:0]             word;

    assign rvalid = vld_q[RESP_LATENCY-1];
    assign rerr   = err_q[RESP_LATENCY-1];

    // A response retiring this cycle frees its slot, so a full pipeline keeps streaming.
    always_comb begin
        err_t = (obi_addr_i[1:0] != 2'b00) | ((obi_addr_i >> (MEM_AW + 2)) != 32'd0);
        gnt   = obi_req_i & ~stall_i & ((cnt_q < CntW'(MAX_OUTSTANDING)) | rvalid);
    end

    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = gnt;
        err_d[0] = gnt & err_t;
        for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({gnt, rvalid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vld_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    // SRAM data appears one cycle after the grant, i.e. alongside stage 1.
    if (RESP_LATENCY == 1) begin : g_direct
        assign word = mem_rdata_i;
    end else begin : g_data_pipe
        logic [31:0] data_q [RESP_LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                data_q[0] <= '0;
                data_q[1] <= mem_rdata_i;
                for (int unsigned i = 2; i < RESP_LATENCY; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign word = data_q[RESP_LATENCY-1];
    end

    always_comb begin
        obi_gnt_o    = gnt;
        mem_req_o    = gnt & ~err_t;
        mem_addr_o   = obi_addr_i[MEM_AW+1:2];
        obi_rvalid_o = rvalid;
        obi_err_o    = rvalid & rerr;
        obi_rdata_o  = (rvalid && !rerr) ? word : 32'd0;
        busy_o       = (cnt_q != '0);
    end

endmodule
